alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; SHALL match ALU_32_bits datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 req0_A, req0_B / req1_A, req1_B  input  WIDTH  operands from requester N.
REQ-007 req0_Op / req1_Op  input  4  ALU_Op code from requester N.
REQ-008 ALU_A, ALU_B  output  WIDTH  operands driven to the shared ALU_32_bits instance.
REQ-009 ALU_Op  output  4  opcode driven to the shared ALU.
REQ-010 ALU_Result  input  WIDTH  combinational ALU result.
REQ-011 ALUFlags  input  4  combinational ALU flags {N,Z,C,V}.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_result  output  WIDTH  captured ALU result.
REQ-016 rsp_flags  output  4  captured ALU flags.
REQ-017 rsp_err  output  1  opcode was unsupported.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-019 In IDLE, grant SHALL be: only one valid -> that requester; both valid -> requester equal to priority pointer ptr; none -> no grant.
REQ-020 reqN_ready SHALL be high only in IDLE and only for the granted requester (combinational from valids and ptr); both readys never high together.
REQ-021 On reqN_valid&reqN_ready: capture A, B, Op, id=N into internal registers; ptr <= ~N; next state EXEC for supported Op, RESP for unsupported Op.
REQ-022 Supported opcodes: 0000-0111, 1011, 1101; all other codes unsupported.
REQ-023 ALU_A, ALU_B, ALU_Op SHALL be driven from the captured registers at all times (stable during EXEC).
REQ-024 EXEC lasts exactly one cycle; at its end capture ALU_Result->rsp_result, ALUFlags->rsp_flags, rsp_err<=0; next state RESP.
REQ-025 Unsupported op path: rsp_result<=0, rsp_flags<=0, rsp_err<=1, rsp_id<=N; ALU not sampled.
REQ-026 In RESP, rsp_valid=1 and rsp_* SHALL hold stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE.
REQ-027 Latency: accept cycle T -> rsp_valid at T+2 (supported) or T+1 (unsupported); back-to-back accept earliest one cycle after response handshake.
REQ-028 Requester that deasserts valid before ready SHALL not be granted; ptr changes only on an accepted grant.
REQ-029 Requests arriving in EXEC/RESP SHALL see ready=0 and wait; no request dropped or duplicated.

Reset
REQ-030 On reset: state IDLE, ptr=0, captured regs=0, ALU_A=ALU_B=0, ALU_Op=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, both reqN_ready=0 during reset cycle.
REQ-031 Reset asserted mid-transaction (EXEC or RESP) SHALL abort it; no response issued afterward.

Verification
REQ-032 req0 A=0x7FFFFFFF B=1 Op=0000 (add) alone -> req0_ready in cycle T, rsp_valid at T+2, rsp_id=0, rsp_result=0x80000000, rsp_flags N=1,V=1,Z=0,C=0.
REQ-033 req0 and req1 both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id alternates starting at 0.
REQ-034 req1 A=0 B=0 Op=0000 -> rsp_result=0, rsp_flags Z=1; hold rsp_ready=0 for 5 cycles -> rsp_valid and all rsp_* stable, both readys 0.
REQ-035 req0 Op=1111 -> rsp_valid at T+1, rsp_err=1, rsp_result=0, rsp_flags=0; ALU outputs not sampled.
REQ-036 Assert reset during EXEC -> next cycle state IDLE, rsp_valid=0, ptr=0; pending request re-granted afterward.
REQ-037 Sweep all supported opcodes with A=0,B=1 through both ports -> rsp_result/rsp_flags equal direct ALU_32_bits outputs for same inputs.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// ----------------------------------------------------------------------------
// Shares one external ALU_32_bits instance between two requesters. Only one
// transaction is in flight at a time. Each transaction runs through three
// states:
//   IDLE : pick a requester and capture its operands.
//   EXEC : the ALU evaluates the captured operands for exactly one cycle.
//   RESP : the result is held until the consumer takes it.
// An unsupported opcode goes straight from IDLE to RESP with an error
// response, and the ALU is never sampled for it.
//
// Ports
//   clk, reset               single clock; synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_A, reqN_B, reqN_Op  operands and opcode from requester N
//   ALU_A, ALU_B, ALU_Op     captured operands driven to the shared ALU
//   ALU_Result, ALUFlags     combinational ALU outputs, flags are {N,Z,C,V}
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   index of the requester that owns the response
//   rsp_result, rsp_flags    captured ALU result and flags
//   rsp_err                  set when the opcode was unsupported
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [3:0]       req0_Op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [3:0]       req1_Op,

    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [3:0]       ALU_Op,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [3:0]       ALUFlags,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // ptr names the requester that wins when both are valid at once.
    logic             ptr;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [3:0]       cap_op;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             accept_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;
    logic             sel_supported;

    // The ALU implements 0000-0111, 1011 and 1101. Every other code gets an
    // error response.
    function automatic logic op_supported(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == 4'b1011) || (op == 4'b1101);
    endfunction

    // Grant selection. A lone valid requester always wins. When both are
    // valid, the pointer decides. The two grants are mutually exclusive by
    // construction.
    assign grant0 = req0_valid & (~req1_valid | ~ptr);
    assign grant1 = req1_valid & (~req0_valid |  ptr);

    // A grant in IDLE is accepted in the same cycle, because ready is
    // asserted for the granted requester whose valid is already high.
    // Acceptance is derived directly from the grants rather than from the
    // ready outputs. This keeps the FSM block free of feedback through its
    // own outputs.
    assign accept        = (state == IDLE) & ~reset & (grant0 | grant1);
    assign accept_id     = grant1;
    assign sel_a         = accept_id ? req1_A  : req0_A;
    assign sel_b         = accept_id ? req1_B  : req0_B;
    assign sel_op        = accept_id ? req1_Op : req0_Op;
    assign sel_supported = op_supported(sel_op);

    // The shared ALU always sees the captured registers, so its inputs stay
    // stable for the whole EXEC cycle. No requester input passes straight
    // through to the ALU.
    assign ALU_A  = cap_a;
    assign ALU_B  = cap_b;
    assign ALU_Op = cap_op;

    // State register. Reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs. Both ready outputs and
    // rsp_valid are forced low during a reset cycle. This prevents a
    // handshake from appearing to complete while the transaction is being
    // discarded.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & ~reset;
                req1_ready = grant1 & ~reset;
                if (accept) begin
                    state_next = sel_supported ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = ~reset;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // - On accept: capture the operands. The pointer moves to the other
    //   requester, and it changes only here.
    // - Unsupported opcode: the error response is built right away, because
    //   EXEC is skipped.
    // - End of EXEC: the ALU output is sampled exactly once.
    // The response registers are left untouched in RESP, so they stay stable
    // while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= 1'b0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_a  <= sel_a;
                        cap_b  <= sel_b;
                        cap_op <= sel_op;
                        rsp_id <= accept_id;
                        ptr    <= ~accept_id;
                        if (!sel_supported) begin
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= ALU_Result;
                    rsp_flags  <= ALUFlags;
                    rsp_err    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// ----------------------------------------------------------------------------
// Testbench for alu_arbiter. It contains a small behavioural stand-in for the
// shared ALU_32_bits, fed from the arbiter's ALU_* outputs.
// - Table-driven single transactions cover the normal path, the
//   unsupported-opcode path and an opcode sweep on both ports.
// - Hand-written sequences cover:
//     * reset values,
//     * round-robin alternation,
//     * a response-side stall,
//     * reset asserted during EXEC.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [3:0]       req0_Op, req1_Op;
    logic [WIDTH-1:0] ALU_A, ALU_B, ALU_Result;
    logic [3:0]       ALU_Op, ALUFlags;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[24];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_Op    (req0_Op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_Op    (req1_Op),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_Op     (ALU_Op),
        .ALU_Result (ALU_Result),
        .ALUFlags   (ALUFlags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    // Behavioural ALU model. Flags are {N,Z,C,V}, and C/V are meaningful only
    // for add/sub. Unsupported codes return an obvious garbage pattern, so a
    // response that wrongly samples the ALU is easy to spot.
    logic [32:0] alu_wide;
    logic        alu_c, alu_v;
    always_comb begin
        alu_wide   = '0;
        ALU_Result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ALU_Op)
            4'b0000: begin
                alu_wide   = {1'b0, ALU_A} + {1'b0, ALU_B};
                ALU_Result = alu_wide[31:0];
                alu_c      = alu_wide[32];
                alu_v      = (ALU_A[31] == ALU_B[31]) && (ALU_Result[31] != ALU_A[31]);
            end
            4'b0001: begin
                alu_wide   = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 33'd1;
                ALU_Result = alu_wide[31:0];
                alu_c      = alu_wide[32];
                alu_v      = (ALU_A[31] != ALU_B[31]) && (ALU_Result[31] != ALU_A[31]);
            end
            4'b0010: ALU_Result = ALU_A & ALU_B;
            4'b0011: ALU_Result = ALU_A | ALU_B;
            4'b0100: ALU_Result = ALU_A ^ ALU_B;
            4'b0101: ALU_Result = ~(ALU_A | ALU_B);
            4'b0110: ALU_Result = ALU_A << ALU_B[4:0];
            4'b0111: ALU_Result = ALU_A >> ALU_B[4:0];
            4'b1011: ALU_Result = {31'd0, $signed(ALU_A) < $signed(ALU_B)};
            4'b1101: ALU_Result = $unsigned($signed(ALU_A) >>> ALU_B[4:0]);
            default: ALU_Result = 32'hDEADBEEF;
        endcase
        ALUFlags = (ALU_Op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                   4'b0101, 4'b0110, 4'b0111, 4'b1011, 4'b1101})
                   ? {ALU_Result[31], ALU_Result == 32'd0, alu_c, alu_v}
                   : 4'hF;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one value and reports a failure if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advances one clock and settles just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation on one port and leaves the other port idle.
    task automatic applyStimulus(input logic port, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] op);
        if (port) begin
            req1_valid = 1'b1; req1_A = a; req1_B = b; req1_Op = op;
        end else begin
            req0_valid = 1'b1; req0_A = a; req0_B = b; req0_Op = op;
        end
    endtask

    // Waits a bounded number of cycles for ready on the given port.
    task automatic waitReady(input logic port);
        for (int i = 0; i < 20; i++) begin
            if (port ? req1_ready : req0_ready) break;
            tick();
        end
    endtask

    // Waits a bounded number of cycles for a response. lat starts at 1,
    // which is the cycle right after the accept edge.
    task automatic waitRsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    // Runs one complete transaction with rsp_ready held high.
    task automatic runTransaction(input vec_t v, input int idx);
        int lat;
        applyStimulus(v.port, v.a, v.b, v.op);
        #1;
        waitReady(v.port);
        checkOutput($sformatf("v%0d_ready", idx), {31'd0, v.port ? req1_ready : req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitRsp(lat);
        checkOutput($sformatf("v%0d_latency", idx), lat, v.lat);
        checkOutput($sformatf("v%0d_rsp_id", idx), {31'd0, rsp_id}, {31'd0, v.port});
        checkOutput($sformatf("v%0d_result", idx), rsp_result, v.res);
        checkOutput($sformatf("v%0d_flags", idx), {28'd0, rsp_flags}, {28'd0, v.flags});
        checkOutput($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
        tick();
        checkOutput($sformatf("v%0d_rsp_done", idx), {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic gid;

        // Stimulus table. Entries 4-13 are the A=0, B=1 opcode sweep on
        // port 0; entries 14-23 repeat the sweep on port 1.
        vecs[0]  = '{1'b0, 32'h7FFFFFFF, 32'h1, 4'h0, 32'h80000000, 4'h9, 1'b0, 2};
        vecs[1]  = '{1'b0, 32'h0,        32'h0, 4'hF, 32'h0,        4'h0, 1'b1, 1};
        vecs[2]  = '{1'b1, 32'h5,        32'h6, 4'hE, 32'h0,        4'h0, 1'b1, 1};
        vecs[3]  = '{1'b1, 32'h3,        32'h3, 4'h8, 32'h0,        4'h0, 1'b1, 1};
        vecs[4]  = '{1'b0, 32'h0, 32'h1, 4'h0, 32'h00000001, 4'h0, 1'b0, 2};
        vecs[5]  = '{1'b0, 32'h0, 32'h1, 4'h1, 32'hFFFFFFFF, 4'h8, 1'b0, 2};
        vecs[6]  = '{1'b0, 32'h0, 32'h1, 4'h2, 32'h00000000, 4'h4, 1'b0, 2};
        vecs[7]  = '{1'b0, 32'h0, 32'h1, 4'h3, 32'h00000001, 4'h0, 1'b0, 2};
        vecs[8]  = '{1'b0, 32'h0, 32'h1, 4'h4, 32'h00000001, 4'h0, 1'b0, 2};
        vecs[9]  = '{1'b0, 32'h0, 32'h1, 4'h5, 32'hFFFFFFFE, 4'h8, 1'b0, 2};
        vecs[10] = '{1'b0, 32'h0, 32'h1, 4'h6, 32'h00000000, 4'h4, 1'b0, 2};
        vecs[11] = '{1'b0, 32'h0, 32'h1, 4'h7, 32'h00000000, 4'h4, 1'b0, 2};
        vecs[12] = '{1'b0, 32'h0, 32'h1, 4'hB, 32'h00000001, 4'h0, 1'b0, 2};
        vecs[13] = '{1'b0, 32'h0, 32'h1, 4'hD, 32'h00000000, 4'h4, 1'b0, 2};
        for (int i = 4; i < 14; i++) begin
            vecs[i + 10]      = vecs[i];
            vecs[i + 10].port = 1'b1;
        end

        reset      = 1'b1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_A = '0; req0_B = '0; req0_Op = '0;
        req1_A = '0; req1_B = '0; req1_Op = '0;

        // Reset state: both ready outputs must stay low, even with valids up.
        tick();
        tick();
        checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_ALU_A", ALU_A, 32'd0);
        checkOutput("rst_ALU_B", ALU_B, 32'd0);
        checkOutput("rst_ALU_Op", {28'd0, ALU_Op}, 32'd0);
        checkOutput("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        checkOutput("rst_rsp_result", rsp_result, 32'd0);
        checkOutput("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;
        tick();

        // Table-driven single transactions.
        rsp_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            runTransaction(vecs[i], i);
        end

        // Alternation: both requesters are valid continuously after reset,
        // so grants must go 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'd5, 32'd3, 4'h0);
        applyStimulus(1'b1, 32'd10, 32'd1, 4'h1);
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20; i++) begin
                if (req0_ready | req1_ready) break;
                tick();
            end
            checkOutput($sformatf("alt%0d_one_ready", k), {31'd0, req0_ready ^ req1_ready}, 32'd1);
            gid = req1_ready;
            checkOutput($sformatf("alt%0d_grant", k), {31'd0, gid}, k % 2);
            tick();
            checkOutput($sformatf("alt%0d_exec_ready", k), {31'd0, req0_ready | req1_ready}, 32'd0);
            waitRsp(lat);
            checkOutput($sformatf("alt%0d_rsp_id", k), {31'd0, rsp_id}, k % 2);
            checkOutput($sformatf("alt%0d_result", k), rsp_result, (k % 2 == 1) ? 32'd9 : 32'd8);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Stall: req1 computes 0+0. The consumer then holds off for 5
        // cycles while req0 waits.
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 32'd0, 32'd0, 4'h0);
        #1;
        waitReady(1'b1);
        checkOutput("stall_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        applyStimulus(1'b0, 32'd1, 32'd1, 4'h0);
        waitRsp(lat);
        checkOutput("stall_latency", lat, 32'd2);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("stall%0d_id", c), {31'd0, rsp_id}, 32'd1);
            checkOutput($sformatf("stall%0d_result", c), rsp_result, 32'd0);
            checkOutput($sformatf("stall%0d_flags", c), {28'd0, rsp_flags}, 32'd4);
            checkOutput($sformatf("stall%0d_err", c), {31'd0, rsp_err}, 32'd0);
            checkOutput($sformatf("stall%0d_readys", c), {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("stall_pending_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        waitRsp(lat);
        checkOutput("stall_pending_id", {31'd0, rsp_id}, 32'd0);
        checkOutput("stall_pending_result", rsp_result, 32'd2);
        tick();

        // Reset during EXEC. The pointer is 1 here, so after reset it must
        // come back as 0.
        applyStimulus(1'b0, 32'h7FFFFFFF, 32'h1, 4'h0);
        #1;
        waitReady(1'b0);
        checkOutput("rexec_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        checkOutput("rexec_in_exec", {31'd0, rsp_valid}, 32'd0);
        reset      = 1'b1;
        req0_valid = 1'b0;
        applyStimulus(1'b1, 32'd4, 32'd4, 4'h0);
        #1;
        checkOutput("rexec_rst_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        reset = 1'b0;
        checkOutput("rexec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        applyStimulus(1'b0, 32'd2, 32'd3, 4'h0);
        #1;
        checkOutput("rexec_ptr0_req0", {31'd0, req0_ready}, 32'd1);
        checkOutput("rexec_ptr0_req1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        waitRsp(lat);
        checkOutput("rexec_r0_id", {31'd0, rsp_id}, 32'd0);
        checkOutput("rexec_r0_result", rsp_result, 32'd5);
        tick();
        checkOutput("rexec_pending_req1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        waitRsp(lat);
        checkOutput("rexec_r1_id", {31'd0, rsp_id}, 32'd1);
        checkOutput("rexec_r1_result", rsp_result, 32'd8);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
